// File: rtl/reg_alu_sequencer.sv
// reg_alu_sequencer: decodes 24-bit instruction words into one-cycle reg_file_alu
// commands and returns the pre-write ALU result over a valid/ready channel.
module reg_alu_sequencer #(
  parameter int IW = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IW-1:0]    instr_data,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [3:0]       RA1,
  output logic [3:0]       RA2,
  output logic [3:0]       WA,
  output logic [7:0]       external_data_in,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic [1:0]       ALUControl,
  input  logic [7:0]       ALUResult,
  output logic [7:0]       res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic nores;
  logic unused_rsvd;
  assign unused_rsvd = ^instr_data[18:16];
  assign instr_ready = (state == IDLE) && reset;
  // RA2 and the immediate share the low byte; ALUSrc picks which one matters
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state            <= IDLE;
      nores            <= 1'b0;
      RA1              <= '0;
      RA2              <= '0;
      WA               <= '0;
      external_data_in <= '0;
      RegWrite         <= 1'b0;
      ALUSrc           <= 1'b0;
      ALUControl       <= '0;
      res_data         <= '0;
      res_valid        <= 1'b0;
      retired          <= '0;
    end else
      case (state)
        IDLE: if (instr_valid) begin
          ALUControl       <= instr_data[23:22];
          ALUSrc           <= instr_data[21];
          RegWrite         <= instr_data[20];
          nores            <= instr_data[19];
          WA               <= instr_data[15:12];
          RA1              <= instr_data[11:8];
          RA2              <= instr_data[7:4];
          external_data_in <= instr_data[7:0];
          state            <= EXEC;
        end
        EXEC: begin
          res_data  <= ALUResult;
          RegWrite  <= 1'b0;
          retired   <= retired + CNT_W'(1);
          res_valid <= !nores;
          state     <= nores ? IDLE : RESP;
        end
        RESP: if (res_ready) begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_reg_alu_sequencer.sv
// tb_reg_alu_sequencer: drives reg_alu_sequencer against a behavioural reg_file_alu
// and scoreboards every returned result against a shadow register model.
module tb_reg_alu_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [23:0] instr_data = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  RA1, RA2, WA;
  logic [7:0]  external_data_in;
  logic        RegWrite, ALUSrc;
  logic [1:0]  ALUControl;
  logic [7:0]  ALUResult;
  logic [7:0]  res_data;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [7:0]  retired;

  reg_alu_sequencer #(.IW(24), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .instr_data(instr_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .RA1(RA1), .RA2(RA2), .WA(WA),
    .external_data_in(external_data_in), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
    .ALUControl(ALUControl), .ALUResult(ALUResult), .res_data(res_data),
    .res_valid(res_valid), .res_ready(res_ready), .retired(retired)
  );

  always #5 clk = ~clk;

  // behavioural reg_file_alu the sequencer drives
  logic [7:0] regs [16] = '{default: 8'h00};
  logic [7:0] op_a, op_b;
  assign op_a = regs[RA1];
  assign op_b = ALUSrc ? external_data_in : regs[RA2];
  assign ALUResult = ALUControl == 2'b00 ? op_a & op_b :
                     ALUControl == 2'b01 ? op_a | op_b :
                     ALUControl == 2'b10 ? op_a + op_b : op_a - op_b;
  always @(posedge clk) if (RegWrite) regs[WA] <= ALUResult;

  logic [7:0] shadow [16] = '{default: 8'h00};
  logic [7:0] exp_q [$];
  logic [7:0] exp_retired = 8'd0;
  int checks = 0;
  int fails = 0;

  function automatic logic [23:0] mk(input logic [1:0] c, input logic s, input logic w,
                                     input logic n, input logic [3:0] wa,
                                     input logic [3:0] ra1, input logic [7:0] lo);
    return {c, s, w, n, 3'b000, wa, ra1, lo};
  endfunction

  function automatic logic [7:0] alu(input logic [1:0] c, input logic [7:0] a, input logic [7:0] b);
    case (c)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a + b;
      default: return a - b;
    endcase
  endfunction

  always @(negedge clk)
    if (reset && res_valid && res_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_unexpected: got res_data=%02h, expected no response", res_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (res_data !== e) begin
          fails++;
          $display("FAIL scoreboard_res_data: got %02h, expected %02h", res_data, e);
        end
      end
    end

  task automatic predict(input logic [23:0] w);
    logic [7:0] a, b, r;
    a = shadow[w[11:8]];
    b = w[21] ? w[7:0] : shadow[w[7:4]];
    r = alu(w[23:22], a, b);
    if (!w[19]) exp_q.push_back(r);
    if (w[20]) shadow[w[15:12]] = r;
    exp_retired++;
  endtask

  // called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic send(input logic [23:0] w);
    int n;
    predict(w);
    instr_data = w;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 20) begin
      fails++;
      $display("FAIL send_timeout: instr_ready=%0b after %0d cycles, expected 1", instr_ready, n);
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr_data = 24'hA5A5A5;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(instr_ready && !res_valid && exp_q.size() == 0) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 20) begin
      fails++;
      $display("FAIL idle_timeout: instr_ready=%0b res_valid=%0b pending=%0d, expected idle", instr_ready, res_valid, exp_q.size());
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({RA1, RA2, WA, external_data_in, RegWrite, ALUSrc, ALUControl, res_data, res_valid, retired, instr_ready} !== 42'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %011h, expected all zero", {RA1, RA2, WA, external_data_in, RegWrite, ALUSrc, ALUControl, res_data, res_valid, retired, instr_ready});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got %0b, expected 1", instr_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_imm();
    send(mk(2'b01, 1'b1, 1'b1, 1'b0, 4'd5, 4'd0, 8'd5));
    checks++;
    if ({RegWrite, WA, external_data_in, ALUSrc, ALUControl, res_valid, instr_ready} !== {1'b1, 4'd5, 8'd5, 1'b1, 2'b01, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL imm_exec: got rw=%0b wa=%0d ext=%02h src=%0b ctl=%0b rv=%0b rdy=%0b, expected 1 5 05 1 01 0 0",
               RegWrite, WA, external_data_in, ALUSrc, ALUControl, res_valid, instr_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({RegWrite, res_valid, res_data, retired} !== {1'b0, 1'b1, 8'd5, 8'd1}) begin
      fails++;
      $display("FAIL imm_resp: got rw=%0b rv=%0b res=%02h retired=%0d, expected 0 1 05 1", RegWrite, res_valid, res_data, retired);
    end
    wait_idle();
    checks++;
    if (regs[5] !== 8'd5) begin
      fails++;
      $display("FAIL imm_regfile: r5=%02h, expected 05", regs[5]);
    end
  endtask

  task automatic test_add_sub();
    send(mk(2'b01, 1'b1, 1'b1, 1'b1, 4'd4, 4'd0, 8'd4) | 24'h070000);
    send(mk(2'b10, 1'b0, 1'b0, 1'b0, 4'd0, 4'd5, 8'h40));
    wait_idle();
    checks++;
    if (res_data !== 8'd9) begin
      fails++;
      $display("FAIL add_result: got %02h, expected 09", res_data);
    end
    send(mk(2'b11, 1'b0, 1'b0, 1'b0, 4'd0, 4'd5, 8'h40));
    wait_idle();
    checks++;
    if (res_data !== 8'd1 || retired !== 8'd4 || retired !== exp_retired) begin
      fails++;
      $display("FAIL sub_result: got res=%02h retired=%0d, expected 01 and 4 (model %0d)", res_data, retired, exp_retired);
    end
  endtask

  task automatic test_wrap();
    send(mk(2'b01, 1'b1, 1'b1, 1'b1, 4'd9, 4'd0, 8'd20));
    send(mk(2'b01, 1'b1, 1'b1, 1'b1, 4'd7, 4'd0, 8'd10));
    send(mk(2'b11, 1'b0, 1'b0, 1'b0, 4'd0, 4'd7, 8'h90));
    wait_idle();
    checks++;
    if (res_data !== 8'hF6) begin
      fails++;
      $display("FAIL sub_wrap: got %02h, expected f6", res_data);
    end
    send(mk(2'b01, 1'b1, 1'b1, 1'b1, 4'd10, 4'd0, 8'hFF));
    send(mk(2'b01, 1'b1, 1'b1, 1'b1, 4'd11, 4'd0, 8'h02));
    send(mk(2'b10, 1'b0, 1'b0, 1'b0, 4'd0, 4'd10, 8'hB0));
    wait_idle();
    checks++;
    if (res_data !== 8'h01) begin
      fails++;
      $display("FAIL add_wrap: got %02h, expected 01", res_data);
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] y;
    y = mk(2'b01, 1'b1, 1'b1, 1'b0, 4'd12, 4'd0, 8'h3C);
    res_ready = 1'b0;
    send(mk(2'b10, 1'b1, 1'b0, 1'b0, 4'd0, 4'd5, 8'h03));
    predict(y);
    instr_data = y;
    instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({res_valid, res_data, instr_ready, RegWrite} !== {1'b1, 8'h08, 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL bp_hold%0d: got rv=%0b res=%02h rdy=%0b rw=%0b, expected 1 08 0 0", i, res_valid, res_data, instr_ready, RegWrite);
      end
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({res_valid, instr_ready, RegWrite} !== 3'b010) begin
      fails++;
      $display("FAIL bp_release: got rv=%0b rdy=%0b rw=%0b, expected 0 1 0", res_valid, instr_ready, RegWrite);
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    checks++;
    if ({RegWrite, WA, instr_ready} !== {1'b1, 4'd12, 1'b0}) begin
      fails++;
      $display("FAIL bp_next_accept: got rw=%0b wa=%0d rdy=%0b, expected 1 12 0", RegWrite, WA, instr_ready);
    end
    wait_idle();
  endtask

  task automatic test_nores_stream();
    logic [7:0] start;
    start = retired;
    for (int i = 1; i <= 3; i++) begin
      send(mk(2'b01, 1'b1, 1'b1, 1'b1, 4'(i), 4'd0, 8'(i * 17)));
      checks++;
      if ({res_valid, instr_ready, RegWrite} !== 3'b001) begin
        fails++;
        $display("FAIL nores_exec%0d: got rv=%0b rdy=%0b rw=%0b, expected 0 0 1", i, res_valid, instr_ready, RegWrite);
      end
      @(posedge clk); #1;
      checks++;
      if ({res_valid, instr_ready, RegWrite} !== 3'b010) begin
        fails++;
        $display("FAIL nores_idle%0d: got rv=%0b rdy=%0b rw=%0b, expected 0 1 0", i, res_valid, instr_ready, RegWrite);
      end
    end
    checks++;
    if (retired - start !== 8'd3 || retired !== exp_retired) begin
      fails++;
      $display("FAIL nores_retired: got %0d (from %0d), expected +3 = %0d", retired, start, exp_retired);
    end
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if (regs[i] !== shadow[i] || regs[i] !== 8'(i * 17)) begin
        fails++;
        $display("FAIL nores_reg%0d: got %02h, expected %02h", i, regs[i], 8'(i * 17));
      end
    end
  endtask

  task automatic test_reset_mid();
    instr_data = mk(2'b01, 1'b1, 1'b1, 1'b0, 4'd13, 4'd0, 8'h77);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    checks++;
    if (RegWrite !== 1'b1) begin
      fails++;
      $display("FAIL mid_exec_rw: got %0b, expected 1", RegWrite);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({RA1, RA2, WA, external_data_in, RegWrite, ALUSrc, ALUControl, res_data, res_valid, retired, instr_ready} !== 42'd0) begin
      fails++;
      $display("FAIL mid_reset_outputs: got %011h, expected all zero", {RA1, RA2, WA, external_data_in, RegWrite, ALUSrc, ALUControl, res_data, res_valid, retired, instr_ready});
    end
    @(posedge clk); #1;
    checks++;
    if (regs[13] !== 8'h00) begin
      fails++;
      $display("FAIL mid_no_write: r13=%02h, expected 00", regs[13]);
    end
    reset = 1'b1;
    exp_retired = 8'd0;
    @(posedge clk); #1;
    checks++;
    if ({instr_ready, retired, res_valid} !== {1'b1, 8'd0, 1'b0}) begin
      fails++;
      $display("FAIL mid_release: got rdy=%0b retired=%0d rv=%0b, expected 1 0 0", instr_ready, retired, res_valid);
    end
    send(mk(2'b00, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 8'h1F));
    wait_idle();
    checks++;
    if (res_data !== 8'h11 || retired !== 8'd1) begin
      fails++;
      $display("FAIL post_reset_op: got res=%02h retired=%0d, expected 11 1", res_data, retired);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_imm();
    test_add_sub();
    test_wrap();
    test_backpressure();
    test_nores_stream();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d responses missing, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
